// File: rtl/test_block.sv
//------------------------------------------------------------------------------
// Module   : test_block
// Purpose  : Clocked 1-bit programmable logic element driven by a 32-entry
//            truth table indexed by {A, INPA_i, INPA_i delayed, OUT_o}.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module test_block (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] FUNC,
  input  logic [1:0]  A,
  input  logic        INPA_i,
  output logic        OUT_o
);

  logic        r_out_q;
  logic        r_inpa_d;
  logic [31:0] r_func_p;
  logic [1:0]  r_a_p;

  logic [4:0]  w_idx;
  logic        w_cfg_change;

  assign w_idx        = {A, INPA_i, r_inpa_d, r_out_q};
  assign w_cfg_change = (FUNC != r_func_p) || (A != r_a_p);

  // A new table or mode forces one cleared cycle before lookups resume,
  // so stale state never indexes into a table it was not built for.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_q  <= 1'b0;
      r_inpa_d <= 1'b0;
      r_func_p <= 32'd0;
      r_a_p    <= 2'd0;
    end else begin
      r_out_q  <= w_cfg_change ? 1'b0 : FUNC[w_idx];
      r_inpa_d <= INPA_i;
      r_func_p <= FUNC;
      r_a_p    <= A;
    end
  end

  assign OUT_o = r_out_q;

endmodule

`default_nettype wire

// File: tb/tb_test_block.sv
//------------------------------------------------------------------------------
// Module   : tb_test_block
// Purpose  : Directed vector bench for test_block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_test_block;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] FUNC;
  logic [1:0]  A;
  logic        INPA_i;
  logic        OUT_o;

  test_block dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .FUNC    (FUNC),
    .A       (A),
    .INPA_i  (INPA_i),
    .OUT_o   (OUT_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [31:0] func;
    logic [1:0]  a;
    logic        inpa;
    logic        exp_out;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   passes;

  task automatic add(input logic rst, input logic [31:0] func, input logic [1:0] a,
                     input logic inpa, input logic exp_out);
    vec_t v;
    v.rst = rst; v.func = func; v.a = a; v.inpa = inpa; v.exp_out = exp_out;
    vecs.push_back(v);
  endtask

  // Drive inputs mid-cycle, then sample just after the following rising edge.
  task automatic step(input logic rst, input logic [31:0] func, input logic [1:0] a,
                      input logic inpa);
    @(negedge clk_i);
    reset_i = rst; FUNC = func; A = a; INPA_i = inpa;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic exp_out);
    checks++;
    if (OUT_o === exp_out) passes++;
    else $display("FAIL %s: OUT_o=%0b expected %0b", name, OUT_o, exp_out);
  endtask

  initial begin
    checks = 0; passes = 0;
    reset_i = 1'b1; FUNC = 32'd0; A = 2'd0; INPA_i = 1'b0;

    // reset
    add(1, 32'h0, 0, 0, 0);
    // follower
    add(0, 32'hF0, 0, 0, 0);   // config change
    add(0, 32'hF0, 0, 0, 0);
    add(0, 32'hF0, 0, 1, 1);
    add(0, 32'hF0, 0, 1, 1);
    add(0, 32'hF0, 0, 0, 0);
    add(0, 32'hF0, 0, 1, 1);
    // rising-edge detector (entered with OUT_o=1, INPA_i history=1)
    add(0, 32'h30, 0, 0, 0);   // config change
    add(0, 32'h30, 0, 0, 0);
    add(0, 32'h30, 0, 1, 1);
    add(0, 32'h30, 0, 1, 0);
    add(0, 32'h30, 0, 1, 0);
    add(0, 32'h30, 0, 1, 0);
    add(0, 32'h30, 0, 0, 0);
    // toggle
    add(0, 32'h9A00, 1, 0, 0); // config change
    add(0, 32'h9A00, 1, 1, 1);
    add(0, 32'h9A00, 1, 0, 1);
    add(0, 32'h9A00, 1, 0, 1);
    add(0, 32'h9A00, 1, 1, 0);
    add(0, 32'h9A00, 1, 0, 0);
    add(0, 32'h9A00, 1, 1, 1);
    add(0, 32'h9A00, 1, 1, 1);
    // configuration change with OUT_o=1
    add(0, 32'hFFFFFFFF, 1, 1, 0);
    add(0, 32'hFFFFFFFF, 1, 1, 1);
    add(0, 32'hFFFFFFFF, 1, 0, 1);
    // mode-only change
    add(0, 32'hFFFFFFFF, 2, 0, 0);
    add(0, 32'hFFFFFFFF, 2, 0, 1);
    // table populated only for A=2
    add(0, 32'h00FF0000, 2, 0, 0);
    add(0, 32'h00FF0000, 2, 1, 1);
    add(0, 32'h00FF0000, 3, 1, 0);
    add(0, 32'h00FF0000, 3, 0, 0);
    add(0, 32'h00FF0000, 2, 0, 0);
    add(0, 32'h00FF0000, 2, 0, 1);
    // reset mid-toggle, then toggle resumes from 0
    add(0, 32'h9A00, 1, 0, 0);
    add(0, 32'h9A00, 1, 1, 1);
    add(0, 32'h9A00, 1, 1, 1);
    add(1, 32'h9A00, 1, 1, 0);
    add(0, 32'h9A00, 1, 0, 0); // post-reset config change
    add(0, 32'h9A00, 1, 1, 1);
    add(0, 32'h9A00, 1, 0, 1);
    add(0, 32'h9A00, 1, 1, 0);
    // held reset with all-ones table, then release
    add(1, 32'hFFFFFFFF, 3, 1, 0);
    add(1, 32'hFFFFFFFF, 3, 1, 0);
    add(0, 32'hFFFFFFFF, 3, 1, 0);
    add(0, 32'hFFFFFFFF, 3, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].func, vecs[i].a, vecs[i].inpa);
      check($sformatf("vec[%0d]", i), vecs[i].exp_out);
    end

    // zero table with random input
    step(1, 32'h0, 0, 0);
    check("zero_reset", 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(0, 32'h0, 0, 1'($urandom_range(0, 1)));
      check($sformatf("zero[%0d]", i), 1'b0);
    end

    // glitches between edges are ignored: follower sees only the edge value
    step(0, 32'hF0, 0, 0);
    check("glitch_cfg", 1'b0);
    @(negedge clk_i);
    INPA_i = 1'b1;
    #2 INPA_i = 1'b0;
    @(posedge clk_i);
    #1 check("glitch_low", 1'b0);
    @(negedge clk_i);
    INPA_i = 1'b0;
    #2 INPA_i = 1'b1;
    @(posedge clk_i);
    #1 check("glitch_high", 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
